regfile_wb_arbiter: RTL and testbench

// Owns the single register-file write port (AD3/WE3/WD3). Arbitrates writebacks from two sources:
// - fixed-latency ALU pipe: never back-pressured;
// - long-latency LSU/MUL-DIV unit: valid/ready, buffered in a small FIFO.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file writeback arbiter
// Purpose: writeback entry type, writeback source enum and the x0 index shared by
//          the FIFO and the arbiter top.
// Ports:   none (package).
package regfile_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] wd;
   } wb_entry_t;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;

   localparam logic [AW-1:0] REG_X0 = '0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering long-latency writebacks
// Purpose: in-order buffer of wb_entry_t between the LSU/MUL-DIV unit and the
//          register-file write port.
// Ports:   clk, rst          clock, asynchronous active-high reset
//          push_i, push_data_i  enqueue request and entry (ignored when full)
//          pop_i             dequeue request (ignored when empty)
//          head_o            entry at the read pointer
//          full_o, empty_o   occupancy flags
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  wb_entry_t push_data_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t     mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);

   // Push is gated by full even when a pop happens the same cycle; the
   // upstream ready is derived from full alone so this never drops data.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign head_o = mem_q[rd_ptr_q];

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending scoreboard
// Purpose: owns the single write port (AD3/WE3/WD3). The fixed-latency ALU pipe
//          has priority; long-latency results queue in wb_fifo and drain in ALU
//          bubbles. A per-register pending scoreboard of long-latency
//          destinations drives the issue stall.
// Ports:   clk, rst                      clock, asynchronous active-high reset
//          alu_valid/alu_rd/alu_wd       ALU writeback (never back-pressured)
//          lsu_valid/lsu_ready/lsu_rd/lsu_wd  long-latency writeback handshake
//          iss_valid/iss_rs1/iss_rs2/iss_rd/iss_long  instruction at issue
//          iss_stall                     hold issue (combinational)
//          AD3/WE3/WD3                   registered register-file write port
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = AW,
   parameter int DATA_WIDTH    = DW,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_wd,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]    lsu_wd,
   input  logic                     iss_valid,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs1,
   input  logic [ADDRESS_WIDTH-1:0] iss_rs2,
   input  logic [ADDRESS_WIDTH-1:0] iss_rd,
   input  logic                     iss_long,
   output logic                     iss_stall,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic                     WE3,
   output logic [DATA_WIDTH-1:0]    WD3
);

   localparam int NREG = 2 ** ADDRESS_WIDTH;

   // Long-latency buffer
   wb_entry_t fifo_push_data;
   wb_entry_t fifo_head;
   logic      fifo_push;
   logic      fifo_pop;
   logic      fifo_full;
   logic      fifo_empty;

   // Write-port registers
   logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
   logic                     we3_q, we3_d;
   logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
   wb_src_e                  wr_src_q, wr_src_d;

   // Scoreboard
   logic [NREG-1:0] pending_q, pending_d;
   logic            alu_win;
   logic            lsu_lands;
   logic            issue_fire;

   assign lsu_ready      = !fifo_full;
   assign fifo_push      = lsu_valid && lsu_ready;
   assign fifo_push_data = '{rd: lsu_rd, wd: lsu_wd};

   // x0 writes from the ALU are dropped outright and do not consume the port,
   // so a queued LSU result may drain in that cycle.
   assign alu_win  = alu_valid && (alu_rd != REG_X0);
   assign fifo_pop = !alu_win && !fifo_empty;

   wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_wb_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (fifo_push_data),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // A popped entry targeting x0 is discarded: the pop happens but WE3 stays low.
   always_comb begin
      we3_d    = 1'b0;
      ad3_d    = ad3_q;
      wd3_d    = wd3_q;
      wr_src_d = wr_src_q;
      if (alu_win) begin
         we3_d    = 1'b1;
         ad3_d    = alu_rd;
         wd3_d    = alu_wd;
         wr_src_d = WB_ALU;
      end else if (fifo_pop && (fifo_head.rd != REG_X0)) begin
         we3_d    = 1'b1;
         ad3_d    = fifo_head.rd;
         wd3_d    = fifo_head.wd;
         wr_src_d = WB_LSU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ad3_q    <= '0;
         we3_q    <= 1'b0;
         wd3_q    <= '0;
         wr_src_q <= WB_ALU;
      end else begin
         ad3_q    <= ad3_d;
         we3_q    <= we3_d;
         wd3_q    <= wd3_d;
         wr_src_q <= wr_src_d;
      end
   end

   assign AD3 = ad3_q;
   assign WE3 = we3_q;
   assign WD3 = wd3_q;

   // The stall covers destinations too (WAW), and a full FIFO stalls issue so
   // the ALU stream is guaranteed to bubble and let the FIFO drain.
   assign iss_stall = iss_valid &&
                      (pending_q[iss_rs1] || pending_q[iss_rs2] ||
                       pending_q[iss_rd]  || fifo_full);

   assign issue_fire = iss_valid && !iss_stall;

   // Clear when the long-latency value is actually on the write port, so the
   // stall drops the cycle after the register file has been written.
   assign lsu_lands = we3_q && (wr_src_q == WB_LSU);

   // Set is applied after clear so that it wins on the same index.
   always_comb begin
      pending_d = pending_q;
      if (lsu_lands) begin
         pending_d[ad3_q] = 1'b0;
      end
      if (issue_fire && iss_long && (iss_rd != REG_X0)) begin
         pending_d[iss_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wd;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_wd;
   logic        iss_valid;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic [4:0]  iss_rd;
   logic        iss_long;
   logic        iss_stall;
   logic [4:0]  AD3;
   logic        WE3;
   logic [31:0] WD3;

   logic [31:0] rf [32];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] awd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] lwd;
      logic        iv;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        il;
      logic        e_stall;
      logic        e_ready;
      logic        e_we;
      logic [4:0]  e_ad;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vecs [10];

   regfile_wb_arbiter #(
      .ADDRESS_WIDTH (5),
      .DATA_WIDTH    (32),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_wd    (alu_wd),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_wd    (lsu_wd),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_long  (iss_long),
      .iss_stall (iss_stall),
      .AD3       (AD3),
      .WE3       (WE3),
      .WD3       (WD3)
   );

   always #5 clk = ~clk;

   // Reference register file fed by the write port.
   always_ff @(posedge clk) begin
      if (WE3) begin
         rf[AD3] <= WD3;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
      iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_long = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic lng);
      iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_long = lng;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      idle();
      rst = 1'b1;

      //                av   ard    awd           lv   lrd    lwd        iv   rs1   rs2   rd    il   stl  rdy  we   ad     wd
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
      vecs[1] = '{1'b1, 5'd0,  32'd123,      1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
      vecs[2] = '{1'b1, 5'd3,  32'd1,        1'b1, 5'd4,  32'd2,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  32'd1};
      vecs[3] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  32'd2};
      vecs[4] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
      vecs[5] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'd77,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
      vecs[6] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
      vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
      vecs[8] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,     1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
      vecs[9] = '{1'b1, 5'd6,  32'h60,       1'b0, 5'd0,  32'd0,     1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h60};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      issue(5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      chk("reset_we3", 32'(WE3), 32'd0);
      chk("reset_ad3", 32'(AD3), 32'd0);
      chk("reset_wd3", WD3, 32'd0);
      chk("reset_ready", 32'(lsu_ready), 32'd1);
      chk("reset_stall", 32'(iss_stall), 32'd0);
      idle();
      tick();
      rst = 1'b0;
      tick();

      // Single-cycle arbitration vectors
      for (int i = 0; i < 10; i++) begin
         alu_valid = vecs[i].av;  alu_rd = vecs[i].ard; alu_wd = vecs[i].awd;
         lsu_valid = vecs[i].lv;  lsu_rd = vecs[i].lrd; lsu_wd = vecs[i].lwd;
         iss_valid = vecs[i].iv;  iss_rs1 = vecs[i].rs1; iss_rs2 = vecs[i].rs2;
         iss_rd = vecs[i].rd;     iss_long = vecs[i].il;
         #1;
         chk($sformatf("vec%0d_stall", i), 32'(iss_stall), 32'(vecs[i].e_stall));
         chk($sformatf("vec%0d_ready", i), 32'(lsu_ready), 32'(vecs[i].e_ready));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_we3", i), 32'(WE3), 32'(vecs[i].e_we));
         if (vecs[i].e_we) begin
            chk($sformatf("vec%0d_ad3", i), 32'(AD3), 32'(vecs[i].e_ad));
            chk($sformatf("vec%0d_wd3", i), WD3, vecs[i].e_wd);
         end
      end
      idle();
      tick();

      // Full FIFO under continuous ALU traffic
      alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h11;
      for (int i = 0; i < 4; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_wd = 32'hA0 + 32'(i);
         #1;
         chk($sformatf("fill%0d_ready", i), 32'(lsu_ready), 32'd1);
         tick();
         chk($sformatf("fill%0d_alu_we3", i), 32'(AD3), 32'd1);
      end
      lsu_rd = 5'd14; lsu_wd = 32'hEE;
      issue(5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      chk("full_ready", 32'(lsu_ready), 32'd0);
      chk("full_stall", 32'(iss_stall), 32'd1);
      tick();
      idle();
      #1;
      chk("full_hold_ready", 32'(lsu_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("drain%0d_we3", i), 32'(WE3), 32'd1);
         chk($sformatf("drain%0d_ad3", i), 32'(AD3), 32'(10 + i));
         chk($sformatf("drain%0d_wd3", i), WD3, 32'hA0 + 32'(i));
      end
      tick();
      chk("drain_done_we3", 32'(WE3), 32'd0);

      // RAW on a long-latency destination
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      #1;
      chk("raw_issue_stall", 32'(iss_stall), 32'd0);
      tick();
      issue(5'd7, 5'd0, 5'd2, 1'b0);
      #1;
      chk("raw_stall0", 32'(iss_stall), 32'd1);
      iss_valid = 1'b0;
      #1;
      chk("raw_novalid_stall", 32'(iss_stall), 32'd0);
      iss_valid = 1'b1;
      for (int i = 1; i < 3; i++) begin
         tick();
         chk($sformatf("raw_stall%0d", i), 32'(iss_stall), 32'd1);
      end
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h77;
      tick();
      lsu_valid = 1'b0;
      #1;
      chk("raw_pop_stall", 32'(iss_stall), 32'd1);
      tick();
      chk("raw_land_we3", 32'(WE3), 32'd1);
      chk("raw_land_ad3", 32'(AD3), 32'd7);
      chk("raw_land_wd3", WD3, 32'h77);
      chk("raw_land_stall", 32'(iss_stall), 32'd1);
      tick();
      chk("raw_release_stall", 32'(iss_stall), 32'd0);
      chk("raw_read_x7", rf[7], 32'h77);
      idle();
      tick();

      // WAW and x0 destinations
      issue(5'd0, 5'd0, 5'd0, 1'b1);
      #1;
      chk("x0_long_stall", 32'(iss_stall), 32'd0);
      tick();
      #1;
      chk("x0_again_stall", 32'(iss_stall), 32'd0);
      issue(5'd0, 5'd0, 5'd12, 1'b1);
      #1;
      chk("waw_first_stall", 32'(iss_stall), 32'd0);
      tick();
      #1;
      chk("waw_second_stall", 32'(iss_stall), 32'd1);
      lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'hC;
      tick();
      lsu_valid = 1'b0;
      tick();
      chk("waw_land_we3", 32'(WE3), 32'd1);
      chk("waw_land_stall", 32'(iss_stall), 32'd1);
      tick();
      chk("waw_release_stall", 32'(iss_stall), 32'd0);
      tick();
      chk("waw_reset_pending", 32'(iss_stall), 32'd1);
      idle();
      tick();

      // Reset mid-operation with two queued entries and pending bits set
      issue(5'd0, 5'd0, 5'd9, 1'b1);
      tick();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h5;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_wd = 32'h1;
      tick();
      lsu_rd = 5'd21; lsu_wd = 32'h2;
      tick();
      lsu_valid = 1'b0;
      chk("pre_rst_we3", 32'(WE3), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_ready", 32'(lsu_ready), 32'd1);
      chk("rst_ad3", 32'(AD3), 32'd0);
      idle();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("post_rst%0d_we3", i), 32'(WE3), 32'd0);
      end
      issue(5'd9, 5'd12, 5'd0, 1'b0);
      #1;
      chk("post_rst_pending", 32'(iss_stall), 32'd0);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
